// File: rtl/brazo_pkg.sv
// rtl/brazo_pkg.sv - shared types, default constants and axis mapping helper for the servo sequencer
// Contents: FSM state enum, default frame/width constants, axis index constants,
//           map_axis() clamp/scale function used by the shared datapath.
package brazo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAP,
    ST_MAP,
    ST_READY
  } state_t;

  localparam int FRAME_CYCLES = 1000000;
  localparam int CENTER       = 75000;
  localparam int SCALE        = 97;
  localparam int RANGE        = 256;
  localparam int MAX_STEP     = 2500;
  localparam int CMD_W        = 17;

  localparam logic [1:0] AX_X = 2'd0;
  localparam logic [1:0] AX_Y = 2'd1;
  localparam logic [1:0] AX_Z = 2'd2;

  // Clamp a signed sample to [-range, +range] and convert it to a pulse width.
  function automatic int map_axis(input logic signed [15:0] s, input int center,
                                  input int scale, input int range);
    int v;
    v = s;
    if (v > range) v = range;
    else if (v < -range) v = -range;
    return center + v * scale;
  endfunction

endpackage

// File: rtl/servo_slew.sv
// rtl/servo_slew.sv - one axis target/command register pair with frame slew limiting
// Ports: clk, rst_n (async active-low); wr/wdata load the target; step applies one
//        slew step to cmd; cmd is the committed pulse width.
module servo_slew
  import brazo_pkg::*;
#(
  parameter int P_CENTER   = brazo_pkg::CENTER,
  parameter int P_MAX_STEP = brazo_pkg::MAX_STEP,
  parameter int P_CMD_W    = brazo_pkg::CMD_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr,
  input  logic [P_CMD_W-1:0] wdata,
  input  logic               step,
  output logic [P_CMD_W-1:0] cmd
);

  localparam logic signed [P_CMD_W+1:0] STEP_S = (P_CMD_W+2)'(P_MAX_STEP);

  logic [P_CMD_W-1:0]        target;
  logic [P_CMD_W-1:0]        tgt_eff;
  logic [P_CMD_W-1:0]        cmd_next;
  logic signed [P_CMD_W+1:0] diff;

  // A step in the same cycle as a target write uses the value being written,
  // so a deferred step lands on the freshly mapped Z target.
  always_comb begin
    tgt_eff  = wr ? wdata : target;
    diff     = $signed({2'b00, tgt_eff}) - $signed({2'b00, cmd});
    cmd_next = tgt_eff;
    if (diff > STEP_S)       cmd_next = cmd + P_CMD_W'(P_MAX_STEP);
    else if (diff < -STEP_S) cmd_next = cmd - P_CMD_W'(P_MAX_STEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target <= P_CMD_W'(P_CENTER);
      cmd    <= P_CMD_W'(P_CENTER);
    end else begin
      if (wr)   target <= wdata;
      if (step) cmd    <= cmd_next;
    end
  end

endmodule

// File: rtl/servo_axis_sequencer.sv
// rtl/servo_axis_sequencer.sv - accelerometer sample to three slew-limited servo pulse widths
// Ports: clk, rst_n (async active-low), en, sample_valid, data_x/y/z (signed 16);
//        cmd_x/y/z committed widths, cmd_update, frame_tick, busy, overrun (sticky).
module servo_axis_sequencer
  import brazo_pkg::*;
#(
  parameter int FRAME_CYCLES = brazo_pkg::FRAME_CYCLES,
  parameter int CENTER       = brazo_pkg::CENTER,
  parameter int SCALE        = brazo_pkg::SCALE,
  parameter int RANGE        = brazo_pkg::RANGE,
  parameter int MAX_STEP     = brazo_pkg::MAX_STEP,
  parameter int CMD_W        = brazo_pkg::CMD_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                sample_valid,
  input  logic signed [15:0]  data_x,
  input  logic signed [15:0]  data_y,
  input  logic signed [15:0]  data_z,
  output logic [CMD_W-1:0]    cmd_x,
  output logic [CMD_W-1:0]    cmd_y,
  output logic [CMD_W-1:0]    cmd_z,
  output logic                cmd_update,
  output logic                frame_tick,
  output logic                busy,
  output logic                overrun
);

  localparam int CNT_W = $clog2(FRAME_CYCLES);

  logic [CNT_W-1:0]   cnt;
  state_t             state;
  logic [1:0]         idx;
  logic signed [15:0] lat_x, lat_y, lat_z;
  logic signed [15:0] sel;
  logic [CMD_W-1:0]   mapped;
  logic [CMD_W-1:0]   wdata;
  logic [2:0]         wr;
  logic               defer;
  logic               in_hold;
  logic               step_now;
  logic [CMD_W-1:0]   cmd_arr [3];

  assign frame_tick = (cnt == CNT_W'(FRAME_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (frame_tick) cnt <= '0;
    else                 cnt <= cnt + CNT_W'(1);
  end

  // Steps are held off while targets are partly rewritten; MAP(Z) itself may
  // step because its target write is forwarded inside servo_slew.
  assign in_hold  = (state == ST_CAP) || (state == ST_MAP && idx != AX_Z);
  assign step_now = (frame_tick || defer) && !in_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      defer      <= 1'b0;
      cmd_update <= 1'b0;
    end else begin
      cmd_update <= step_now;
      if (step_now)        defer <= 1'b0;
      else if (frame_tick) defer <= 1'b1;
    end
  end

  // Shared clamp/scale datapath, time-multiplexed by the MAP axis index.
  always_comb begin
    case (idx)
      AX_X:    sel = lat_x;
      AX_Y:    sel = lat_y;
      default: sel = lat_z;
    endcase
    mapped = CMD_W'(map_axis(sel, CENTER, SCALE, RANGE));
    wdata  = en ? mapped : CMD_W'(CENTER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= AX_X;
      busy    <= 1'b0;
      overrun <= 1'b0;
      lat_x   <= '0;
      lat_y   <= '0;
      lat_z   <= '0;
    end else if (!en) begin
      state   <= ST_IDLE;
      idx     <= AX_X;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_READY: begin
          if (sample_valid) begin
            lat_x <= data_x;
            lat_y <= data_y;
            lat_z <= data_z;
            state <= ST_CAP;
            busy  <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CAP: begin
          if (sample_valid) overrun <= 1'b1;
          state <= ST_MAP;
          idx   <= AX_X;
        end
        default: begin
          if (sample_valid) overrun <= 1'b1;
          if (idx == AX_Z) begin
            state <= ST_READY;
            busy  <= 1'b0;
            idx   <= AX_X;
          end else begin
            idx <= idx + 2'd1;
          end
        end
      endcase
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_axis
    // With en low every cycle writes CENTER, parking the targets.
    assign wr[i] = !en || (state == ST_MAP && idx == 2'(i));

    servo_slew #(
      .P_CENTER  (CENTER),
      .P_MAX_STEP(MAX_STEP),
      .P_CMD_W   (CMD_W)
    ) u_slew (
      .clk  (clk),
      .rst_n(rst_n),
      .wr   (wr[i]),
      .wdata(wdata),
      .step (step_now),
      .cmd  (cmd_arr[i])
    );
  end

  assign cmd_x = cmd_arr[0];
  assign cmd_y = cmd_arr[1];
  assign cmd_z = cmd_arr[2];

endmodule

// File: tb/tb_servo_axis_sequencer.sv
// tb/tb_servo_axis_sequencer.sv - directed self-checking bench for servo_axis_sequencer
module tb_servo_axis_sequencer;

  localparam int FC = 50;

  logic               clk;
  logic               rst_n;
  logic               en;
  logic               sample_valid;
  logic signed [15:0] data_x, data_y, data_z;
  logic [16:0]        cmd_x, cmd_y, cmd_z;
  logic               cmd_update, frame_tick, busy, overrun;

  int checks;
  int failures;

  servo_axis_sequencer #(.FRAME_CYCLES(FC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .sample_valid(sample_valid),
    .data_x      (data_x),
    .data_y      (data_y),
    .data_z      (data_z),
    .cmd_x       (cmd_x),
    .cmd_y       (cmd_y),
    .cmd_z       (cmd_z),
    .cmd_update  (cmd_update),
    .frame_tick  (frame_tick),
    .busy        (busy),
    .overrun     (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * FC; i++) begin
      cyc();
      if (frame_tick) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL wait_tick: no frame_tick within %0d cycles", 2 * FC);
    end
  endtask

  task automatic step_wait();
    wait_tick();
    cyc();
  endtask

  task automatic send(input int x, input int y, input int z);
    sample_valid = 1'b1;
    data_x = 16'(x);
    data_y = 16'(y);
    data_z = 16'(z);
    cyc();
    sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    en = 1'b1;
    repeat (3) cyc();
    checks++;
    if (cmd_x !== 17'd75000 || cmd_y !== 17'd75000 || cmd_z !== 17'd75000) begin
      failures++;
      $display("FAIL reset_cmd: got %0d/%0d/%0d want 75000", cmd_x, cmd_y, cmd_z);
    end
    checks++;
    if ({cmd_update, frame_tick, busy, overrun} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got %b want 0000", {cmd_update, frame_tick, busy, overrun});
    end
    rst_n = 1'b1;
    n = 0;
    while (!frame_tick && n < 2 * FC) begin
      cyc();
      n++;
    end
    checks++;
    if (n !== FC - 1) begin
      failures++;
      $display("FAIL reset_first_tick: got %0d cycles want %0d", n, FC - 1);
    end
  endtask

  task automatic test_nominal();
    cyc();
    send(256, -256, 0);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL nominal_busy_cap: got %b want 1", busy);
    end
    repeat (4) cyc();
    checks++;
    if (busy !== 1'b0 || cmd_update !== 1'b0) begin
      failures++;
      $display("FAIL nominal_idle: busy=%b cmd_update=%b want 0 0", busy, cmd_update);
    end
    step_wait();
    checks++;
    if (cmd_x !== 17'd77500 || cmd_y !== 17'd72500 || cmd_z !== 17'd75000 || cmd_update !== 1'b1) begin
      failures++;
      $display("FAIL nominal_step1: got %0d/%0d/%0d upd=%b want 77500/72500/75000 upd=1",
               cmd_x, cmd_y, cmd_z, cmd_update);
    end
    cyc();
    checks++;
    if (cmd_update !== 1'b0) begin
      failures++;
      $display("FAIL nominal_update_pulse: got %b want 0", cmd_update);
    end
    repeat (9) step_wait();
    checks++;
    if (cmd_x !== 17'd99832 || cmd_y !== 17'd50168) begin
      failures++;
      $display("FAIL nominal_step10: got %0d/%0d want 99832/50168", cmd_x, cmd_y);
    end
  endtask

  task automatic test_clamp();
    cyc();
    send(1000, -32768, 5);
    step_wait();
    checks++;
    if (cmd_x !== 17'd99832 || cmd_y !== 17'd50168 || cmd_z !== 17'd75485) begin
      failures++;
      $display("FAIL clamp: got %0d/%0d/%0d want 99832/50168/75485", cmd_x, cmd_y, cmd_z);
    end
  endtask

  task automatic test_overrun_drop();
    cyc();
    send(300, -300, 5);
    cyc();
    sample_valid = 1'b1;
    data_x = 16'sd0;
    data_y = 16'sd0;
    data_z = 16'sd0;
    cyc();
    sample_valid = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set: got %b want 1", overrun);
    end
    step_wait();
    checks++;
    if (cmd_x !== 17'd99832 || cmd_y !== 17'd50168) begin
      failures++;
      $display("FAIL overrun_dropped_sample: got %0d/%0d want 99832/50168", cmd_x, cmd_y);
    end
  endtask

  task automatic test_park();
    en = 1'b0;
    sample_valid = 1'b1;
    data_x = -16'sd256;
    cyc();
    sample_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL park_ignore: busy=%b overrun=%b want 0 0", busy, overrun);
    end
    step_wait();
    checks++;
    if (cmd_x !== 17'd97332) begin
      failures++;
      $display("FAIL park_step1: got %0d want 97332", cmd_x);
    end
    repeat (9) step_wait();
    checks++;
    if (cmd_x !== 17'd75000 || cmd_y !== 17'd75000 || cmd_z !== 17'd75000) begin
      failures++;
      $display("FAIL park_center: got %0d/%0d/%0d want 75000", cmd_x, cmd_y, cmd_z);
    end
    en = 1'b1;
  endtask

  task automatic test_back_to_back();
    cyc();
    send(-256, 0, 0);
    repeat (4) cyc();
    sample_valid = 1'b1;
    data_x = 16'sd20;
    data_y = 16'sd0;
    data_z = 16'sd0;
    cyc();
    sample_valid = 1'b0;
    checks++;
    if (overrun !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL ready_resample: overrun=%b busy=%b want 0 1", overrun, busy);
    end
    step_wait();
    checks++;
    if (cmd_x !== 17'd76940) begin
      failures++;
      $display("FAIL ready_latest_wins: got %0d want 76940", cmd_x);
    end
  endtask

  task automatic test_deferred();
    wait_tick();
    repeat (47) cyc();
    send(-5, 10, -10);
    cyc();
    cyc();
    checks++;
    if (frame_tick !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL defer_align: frame_tick=%b busy=%b want 1 1", frame_tick, busy);
    end
    cyc();
    checks++;
    if (cmd_update !== 1'b0 || cmd_x !== 17'd76940) begin
      failures++;
      $display("FAIL defer_hold: upd=%b cmd_x=%0d want 0 76940", cmd_update, cmd_x);
    end
    cyc();
    checks++;
    if (cmd_update !== 1'b1 || cmd_x !== 17'd74515 || cmd_y !== 17'd75970 || cmd_z !== 17'd74030) begin
      failures++;
      $display("FAIL defer_apply: upd=%b got %0d/%0d/%0d want 1 74515/75970/74030",
               cmd_update, cmd_x, cmd_y, cmd_z);
    end
    cyc();
    checks++;
    if (cmd_update !== 1'b0) begin
      failures++;
      $display("FAIL defer_once: got %b want 0", cmd_update);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    repeat (3) cyc();
    send(0, 0, 0);
    rst_n = 1'b0;
    #2;
    checks++;
    if (cmd_x !== 17'd75000 || busy !== 1'b0 || overrun !== 1'b0 || cmd_update !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: cmd_x=%0d busy=%b overrun=%b upd=%b want 75000 0 0 0",
               cmd_x, busy, overrun, cmd_update);
    end
    cyc();
    rst_n = 1'b1;
    n = 0;
    while (!frame_tick && n < 2 * FC) begin
      cyc();
      n++;
    end
    checks++;
    if (n !== FC - 1) begin
      failures++;
      $display("FAIL mid_reset_tick: got %0d cycles want %0d", n, FC - 1);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    en = 1'b1;
    sample_valid = 1'b0;
    data_x = '0;
    data_y = '0;
    data_z = '0;
    test_reset();
    test_nominal();
    test_clamp();
    test_overrun_drop();
    test_park();
    test_back_to_back();
    test_deferred();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/servo_axis_sequencer.md
Name: servo_axis_sequencer

Overview:
- Sits between the accelerometer sample interface and the three servo PWM channels of the arm.
- Captures one X/Y/Z sample set and maps each axis to a servo pulse-width command, using one shared clamp/scale datapath time-multiplexed over the axes.
- Slew-limits the commands and commits them only on a 20 ms frame boundary, so a PWM channel never sees a mid-frame width change.

Parameters:
- FRAME_CYCLES, 1000000, clock cycles per servo frame (20 ms at 50 MHz)
- CENTER, 75000, neutral pulse width in cycles (1.5 ms)
- SCALE, 97, cycles of width per accelerometer LSB
- RANGE, 256, clamp magnitude in LSB (1 g)
- MAX_STEP, 2500, maximum command change per frame, in cycles
- CMD_W, 17, command width in bits

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous active-low reset
- en  in  1  tracking enable; low = park all servos at CENTER
- sample_valid  in  1  one-cycle strobe; data_x/y/z valid this cycle
- data_x, data_y, data_z  in  16 each  signed two's-complement axis samples
- cmd_x, cmd_y, cmd_z  out  CMD_W each  committed pulse widths, in cycles
- cmd_update  out  1  one-cycle pulse in the cycle cmd_* change
- frame_tick  out  1  one-cycle pulse at each frame end
- busy  out  1  high while the FSM is in CAP or MAP
- overrun  out  1  sticky; a sample was dropped

Behaviour:
- Reset (async, rst_n=0):
  - cmd_*=CENTER, internal targets=CENTER
  - cmd_update=0, frame_tick=0, busy=0, overrun=0
  - frame counter=0, FSM=IDLE, deferred flag=0
- Frame counter:
  - Free-runs 0..FRAME_CYCLES-1 and wraps; runs regardless of en.
  - frame_tick=1 exactly when the count is FRAME_CYCLES-1.
- FSM states: IDLE, CAP, MAP (axis index 0..2), READY.
  - IDLE: sample_valid & en -> latch data_x/y/z, go to CAP.
  - CAP: one cycle, go to MAP with index 0.
  - MAP: one axis per cycle, X then Y then Z; each cycle writes target[i]; after Z go to READY.
  - READY: sample_valid & en -> re-latch and go to CAP (latest sample wins, not an overrun); otherwise go to IDLE.
- Latency: sample_valid at cycle t -> all three targets updated by the end of cycle t+4.
- Mapping, per axis:
  - Clamp the signed 16-bit sample to [-RANGE, +RANGE].
  - target = CENTER + clamped*SCALE, computed signed, wide enough to hold it.
  - Result is stored as unsigned CMD_W. Defaults give a range of 50168..99832.
- Slew step, on frame_tick (applied in the following cycle, together with the cmd_update pulse):
  - diff = target - cmd.
  - If |diff| <= MAX_STEP, cmd = target.
  - Otherwise cmd = cmd + sign(diff)*MAX_STEP.
  - Stepping continues on every frame until cmd==target, with no new samples needed.
  - cmd_update pulses on every step cycle, even if no value changed.
- Boundary conditions:
  - frame_tick while the FSM is in CAP or MAP: the step is deferred (flag set) and applied in the cycle after MAP(Z) completes, so all three axes always step from a coherent target set.
  - sample_valid while in CAP or MAP: sample dropped, overrun set to 1. overrun clears only on reset or en=0.
  - en=0: sample_valid ignored; FSM forced to IDLE; targets forced to CENTER; cmds keep slewing to CENTER on frame ticks (controlled park, no jump).
  - Reset mid-operation: all state returns to the reset values immediately; counter restarts at 0.

Decomposition:
- Shared package brazo_pkg holds:
  - FSM state enum
  - default constants FRAME_CYCLES, CENTER, SCALE, RANGE, MAX_STEP, CMD_W
  - axis index constants AX_X=0, AX_Y=1, AX_Z=2
- One natural sub-module, servo_slew: owns one axis's target/cmd register pair and the step logic, instantiated three times.
- The clamp/scale datapath and the FSM remain in the top of this block.

Test Plan:
- Reset check: assert rst_n=0 mid-frame -> cmd_*=75000, all flags 0, frame_tick next asserts 999999 cycles after release.
- Nominal sample: x=+256, y=-256, z=0 -> targets 99832/50168/75000.
  - After first tick + 1 cycle: cmd_x=77500, cmd_y=72500, cmd_z=75000, cmd_update=1.
  - After 10th tick: cmd_x=99832, cmd_y=50168.
- Clamp: x=+1000, y=-32768 -> targets 99832 and 50168.
- Overrun: sample_valid at t and t+2 -> second sample dropped, overrun=1; same pair of strobes at t and t+5 (READY) -> second accepted, overrun stays 0.
- Deferred step: force frame_tick to land in MAP(Y) -> cmd_* update exactly once, in the cycle after MAP(Z), using the new targets.
- Park: with cmd_x=99832, drop en -> sample_valid ignored, cmd_x steps 97332, 94832, ... reaching 75000 after 10 ticks, overrun cleared.
